wb_timeout_arbiter: RTL and testbench
=====================================

WB_TIMEOUT_ARBITER -- requirements
Module: wb_timeout_arbiter

Interface
REQ-001 SHALL have parameter M, default 4: number of Wishbone masters, legal range 2..16.
REQ-002 SHALL have parameter TIMEOUT, default 1023: ack-less cycles tolerated per grant, legal range 1..65535.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port m_cyc_i_all, input, M bits: per-master cycle request.
REQ-006 SHALL have port any_s_ack, input, 1 bit: OR of all slave acks.
REQ-007 SHALL have port grant_onehot, output, M bits: registered one-hot grant.
REQ-008 SHALL have port grant_bin, output, Mw bits: binary index of grant_onehot, where Mw = log2(M).
REQ-009 SHALL have port grant_valid, output, 1 bit: 1 when grant_onehot is non-zero.
REQ-010 SHALL have port m_err_o_all, output, M bits: one-cycle timeout error to the affected master.
REQ-011 SHALL have port trigger, output, 1 bit: one-cycle pulse on each timeout event.
REQ-012 SHALL have port trace_signal, output, 32 bits: debug trace word.

Function
REQ-013 SHALL implement the FSM states IDLE, GRANT and FLUSH.
REQ-014 In IDLE, when any eligible request is present, SHALL pick one round-robin, starting at the master after rr_ptr, register grant_onehot, load rr_ptr with the winner, and enter GRANT; grant is visible 1 cycle after the request is seen.
REQ-015 In IDLE, when no eligible request is present, SHALL keep grant_onehot = 0.
REQ-016 In GRANT, SHALL hold the grant while the granted master's cyc = 1, regardless of other requests; no preemption.
REQ-017 In GRANT, when the granted master's cyc = 0, SHALL clear the grant next edge and return to IDLE, giving 1 dead cycle between owners.
REQ-018 SHALL run a wait counter of width log2(TIMEOUT+1) that clears on entry to GRANT and on every cycle with any_s_ack = 1, and increments otherwise.
REQ-019 When the counter equals TIMEOUT with any_s_ack = 0 and cyc still 1, SHALL pulse m_err_o_all[owner] and trigger for exactly 1 cycle, clear the grant, set mask[owner], and enter FLUSH.
REQ-020 In FLUSH, SHALL immediately return to IDLE; a masked master SHALL be ineligible until its cyc is sampled 0, which clears its mask bit.
REQ-021 On simultaneous ack and timeout, ack SHALL win: counter clears, no error.
REQ-022 On simultaneous cyc drop and timeout, the cyc drop SHALL win: normal release, no error.
REQ-023 trace_signal SHALL be {timeout_cnt[7:0] saturating at 255, grant_cnt[7:0] wrapping, 4'b0, grant_bin zero-extended to 4 bits, 6'b0, state[1:0]}, with IDLE = 0, GRANT = 1, FLUSH = 2.
REQ-024 grant_bin and grant_valid SHALL be combinational decodes of grant_onehot.

Reset
REQ-025 While reset = 0, SHALL force grant_onehot, m_err_o_all, trigger, counters and mask to 0, state to IDLE, and rr_ptr to M-1, so master 0 has first priority.
REQ-026 Reset asserted mid-GRANT SHALL drop the grant asynchronously with no error pulse.
REQ-027 Arbitration SHALL resume on the first edge after reset deasserts.

Configuration
REQ-028 With macro WB_ARB_TIMEOUT_EN defined, SHALL implement REQ-018..REQ-022 as specified.
REQ-029 Without WB_ARB_TIMEOUT_EN, SHALL omit the counter and mask, make FLUSH unreachable, tie m_err_o_all and trigger to 0, and tie trace_signal[31:24] to 0.

Structure
REQ-030 Package wb_arb_pkg SHALL hold the state encoding, trace field offsets/widths, and the log2 function.
REQ-031 The round-robin picker SHALL be the one combinational sub-module wb_rr_pick, with inputs (req, rr_ptr) and a one-hot output.

Verification
REQ-032 M=4, reset, then cyc = 4'b1111 -> grant sequence 0,1,2,3,0, each following a 1-cycle idle gap after the owner drops cyc.
REQ-033 Master 2 owns the grant, master 0 requests for 50 cycles -> grant stays 4'b0100 until cyc[2] = 0, then 4'b0001 two edges later.
REQ-034 TIMEOUT=8, grant to master 1, no ack -> m_err_o_all = 4'b0010 and trigger pulse on cycle 9 after grant; grant = 0; master 1 ignored until cyc[1] falls; trace_signal[31:24] = 1.
REQ-035 TIMEOUT=8, ack arriving on cycle 8 -> no error, counter restarts.
REQ-036 reset driven low mid-GRANT -> grant_onehot = 0 within the same cycle, with no error pulse.
REQ-037 Build without WB_ARB_TIMEOUT_EN and run a 2000-cycle stall -> no error, grant held.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone timeout arbiter.
//   - arb_state_t   : FSM state encoding (also exported on the trace word)
//   - TRACE_*       : bit offsets / widths of the fields in trace_signal
//   - clog2         : ceiling log2 used to size index and counter vectors
//   - onehot_to_idx : one-hot (up to 16 bits) to binary index
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_FLUSH = 2'd2
    } arb_state_t;

    // trace_signal = {timeouts[7:0], grants[7:0], 4'b0, grant_bin[3:0], 6'b0, state[1:0]}
    localparam int TRACE_TO_LSB = 24;
    localparam int TRACE_TO_W   = 8;
    localparam int TRACE_GC_LSB = 16;
    localparam int TRACE_GC_W   = 8;
    localparam int TRACE_GB_LSB = 8;
    localparam int TRACE_GB_W   = 4;
    localparam int TRACE_ST_LSB = 0;
    localparam int TRACE_ST_W   = 2;

    // Ceiling log2, never less than 1 so vectors stay legal for tiny values.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 20; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                r = r | 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker.
//   req    [M-1:0]  : eligible requests
//   rr_ptr [MW-1:0] : index of the previous winner; search starts just above it
//   pick   [M-1:0]  : one-hot winner, zero when req is zero
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter  int M  = 4,
    localparam int MW = clog2(M)
) (
    input  logic [M-1:0]  req,
    input  logic [MW-1:0] rr_ptr,
    output logic [M-1:0]  pick
);

    logic [M-1:0] above;
    logic [M-1:0] req_hi;

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_above
            assign above[gi] = (MW'(gi) > rr_ptr);
        end
    endgenerate

    // Lowest set bit among requesters above the pointer wins; if there are
    // none, wrap around and take the lowest set bit overall. x & (~x + 1)
    // isolates the lowest set bit.
    assign req_hi = req & above;
    assign pick   = (|req_hi) ? (req_hi & (~req_hi + M'(1)))
                              : (req & (~req + M'(1)));

endmodule

// File: rtl/wb_timeout_arbiter.sv
// Round-robin Wishbone bus arbiter with optional ack-timeout recovery.
// Define WB_ARB_TIMEOUT_EN to build the ack watchdog, the per-master mask
// and the error/trigger pulses; without it they are tied off.
//   clk, reset        : clock, asynchronous active-low reset
//   m_cyc_i_all [M]   : per-master cycle request
//   any_s_ack         : OR of all slave acks
//   grant_onehot [M]  : registered one-hot grant
//   grant_bin [MW]    : binary index of grant_onehot
//   grant_valid       : grant_onehot non-zero
//   m_err_o_all [M]   : one-cycle timeout error to the stalled master
//   trigger           : one-cycle pulse per timeout event
//   trace_signal [32] : debug word (layout in wb_arb_pkg)
module wb_timeout_arbiter
    import wb_arb_pkg::*;
#(
    parameter  int M       = 4,
    parameter  int TIMEOUT = 1023,
    localparam int MW      = clog2(M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [M-1:0]  m_cyc_i_all,
    input  logic          any_s_ack,
    output logic [M-1:0]  grant_onehot,
    output logic [MW-1:0] grant_bin,
    output logic          grant_valid,
    output logic [M-1:0]  m_err_o_all,
    output logic          trigger,
    output logic [31:0]   trace_signal
);

    arb_state_t    state_reg, state_next;
    logic [M-1:0]  grant_reg, grant_next;
    logic [MW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [7:0]    grant_cnt_reg, grant_cnt_next;
    logic [M-1:0]  eligible;
    logic [M-1:0]  pick;
    logic          owner_cyc;
    logic          timeout_hit;
    logic [7:0]    timeout_byte;

    wb_rr_pick #(.M(M)) u_pick (
        .req    (eligible),
        .rr_ptr (rr_ptr_reg),
        .pick   (pick)
    );

    assign owner_cyc = |(grant_reg & m_cyc_i_all);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_reg, wait_next;
    logic [M-1:0]  mask_reg, mask_next;
    logic [M-1:0]  err_reg, err_next;
    logic          trig_reg, trig_next;
    logic [7:0]    to_cnt_reg, to_cnt_next;

    assign eligible = m_cyc_i_all & ~mask_reg;
    // A cyc drop or an ack in the same cycle both take precedence.
    assign timeout_hit = owner_cyc && !any_s_ack && (wait_reg == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_reg   <= '0;
            mask_reg   <= '0;
            err_reg    <= '0;
            trig_reg   <= 1'b0;
            to_cnt_reg <= '0;
        end else begin
            wait_reg   <= wait_next;
            mask_reg   <= mask_next;
            err_reg    <= err_next;
            trig_reg   <= trig_next;
            to_cnt_reg <= to_cnt_next;
        end
    end

    always_comb begin
        wait_next   = wait_reg;
        // A mask bit survives only while its master keeps cyc asserted.
        mask_next   = mask_reg & m_cyc_i_all;
        err_next    = '0;
        trig_next   = 1'b0;
        to_cnt_next = to_cnt_reg;
        if (state_reg == ST_IDLE) begin
            // Zero while idle so every new grant starts counting from 0.
            wait_next = '0;
        end else if (state_reg == ST_GRANT && owner_cyc) begin
            if (any_s_ack) begin
                wait_next = '0;
            end else if (timeout_hit) begin
                err_next  = grant_reg;
                trig_next = 1'b1;
                mask_next = mask_next | grant_reg;
                if (to_cnt_reg != 8'hFF) begin
                    to_cnt_next = to_cnt_reg + 8'd1;
                end
            end else begin
                wait_next = wait_reg + CW'(1);
            end
        end
    end

    assign m_err_o_all  = err_reg;
    assign trigger      = trig_reg;
    assign timeout_byte = to_cnt_reg;
`else
    localparam int unused_timeout = TIMEOUT;
    logic unused_ack;
    assign unused_ack   = any_s_ack;
    assign eligible     = m_cyc_i_all;
    assign timeout_hit  = 1'b0;
    assign m_err_o_all  = '0;
    assign trigger      = 1'b0;
    assign timeout_byte = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            rr_ptr_reg    <= MW'(M - 1);
            grant_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_cnt_reg <= grant_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_cnt_next = grant_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|eligible) begin
                    grant_next     = pick;
                    rr_ptr_next    = MW'(onehot_to_idx(16'(pick)));
                    grant_cnt_next = grant_cnt_reg + 8'd1;
                    state_next     = ST_GRANT;
                end else begin
                    grant_next = '0;
                end
            end
            ST_GRANT: begin
                // No preemption: only the owner's cyc or the watchdog end a grant.
                if (!owner_cyc) begin
                    grant_next = '0;
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    grant_next = '0;
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
            default: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign grant_onehot = grant_reg;
    assign grant_bin    = MW'(onehot_to_idx(16'(grant_reg)));
    assign grant_valid  = |grant_reg;

    always_comb begin
        trace_signal = '0;
        trace_signal[TRACE_TO_LSB +: TRACE_TO_W] = timeout_byte;
        trace_signal[TRACE_GC_LSB +: TRACE_GC_W] = grant_cnt_reg;
        trace_signal[TRACE_GB_LSB +: TRACE_GB_W] = TRACE_GB_W'(grant_bin);
        trace_signal[TRACE_ST_LSB +: TRACE_ST_W] = state_reg;
    end

endmodule

// File: tb/tb_wb_timeout_arbiter.sv
module tb_wb_timeout_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  m_cyc_i_all;
    logic        any_s_ack;
    logic [3:0]  grant_onehot;
    logic [1:0]  grant_bin;
    logic        grant_valid;
    logic [3:0]  m_err_o_all;
    logic        trigger;
    logic [31:0] trace_signal;

    wb_timeout_arbiter #(.M(4), .TIMEOUT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .m_cyc_i_all  (m_cyc_i_all),
        .any_s_ack    (any_s_ack),
        .grant_onehot (grant_onehot),
        .grant_bin    (grant_bin),
        .grant_valid  (grant_valid),
        .m_err_o_all  (m_err_o_all),
        .trigger      (trigger),
        .trace_signal (trace_signal)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc_cnt++;

    typedef struct {
        int         stamp;
        logic [3:0] g;
        logic [3:0] e;
        logic       t;
    } ev_t;

    ev_t exp_q[$];

    // Expect an output change (grant/err/trigger) dly rising edges from now.
    task automatic push(input int dly, input logic [3:0] g, input logic [3:0] e, input logic t);
        ev_t ev;
        ev.stamp = cyc_cnt + dly;
        ev.g     = g;
        ev.e     = e;
        ev.t     = t;
        exp_q.push_back(ev);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end else begin
            $display("ok   %s value=0x%08h", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every change of the grant/error outputs is one transaction.
    logic [3:0] prev_g = '0, prev_e = '0;
    logic       prev_t = 1'b0;
    always @(negedge clk) begin
        if (mon_en && ({grant_onehot, m_err_o_all, trigger} != {prev_g, prev_e, prev_t})) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cycle=%0d grant=%b err=%b trig=%b",
                         cyc_cnt, grant_onehot, m_err_o_all, trigger);
            end else begin
                ev_t ev;
                logic [1:0] eb;
                ev = exp_q.pop_front();
                eb = '0;
                for (int i = 0; i < 4; i++) begin
                    if (ev.g[i]) eb = 2'(i);
                end
                if (cyc_cnt != ev.stamp || grant_onehot !== ev.g || m_err_o_all !== ev.e ||
                    trigger !== ev.t || grant_bin !== eb || grant_valid !== (ev.g != 0)) begin
                    failures++;
                    $display("FAIL grant_event cycle=%0d/%0d grant=%b/%b bin=%0d/%0d valid=%b err=%b/%b trig=%b/%b (actual/expected)",
                             cyc_cnt, ev.stamp, grant_onehot, ev.g, grant_bin, eb, grant_valid,
                             m_err_o_all, ev.e, trigger, ev.t);
                end else begin
                    $display("ok   grant_event cycle=%0d grant=%b err=%b trig=%b",
                             cyc_cnt, grant_onehot, m_err_o_all, trigger);
                end
            end
        end
        prev_g = grant_onehot;
        prev_e = m_err_o_all;
        prev_t = trigger;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int owner;
        int nxt;
        logic [3:0] one;
        one = 4'b0001;

        reset       = 1'b1;
        m_cyc_i_all = '0;
        any_s_ack   = 1'b0;
        #1 reset = 1'b0;
        step(2);
        chk("reset_grant", 32'(grant_onehot), 32'h0);
        chk("reset_valid", 32'(grant_valid), 32'h0);
        chk("reset_err", 32'(m_err_o_all), 32'h0);
        chk("reset_trigger", 32'(trigger), 32'h0);
        chk("reset_trace", trace_signal, 32'h0);
        mon_en = 1'b1;

        // Round robin 0,1,2,3,0 with all masters requesting.
        reset       = 1'b1;
        m_cyc_i_all = 4'b1111;
        push(1, 4'b0001, 4'b0000, 1'b0);
        owner = 0;
        for (int s = 0; s < 4; s++) begin
            step(3);
            nxt = (owner + 1) % 4;
            m_cyc_i_all[owner] = 1'b0;
            push(1, 4'b0000, 4'b0000, 1'b0);
            push(2, one << nxt, 4'b0000, 1'b0);
            step(1);
            m_cyc_i_all = 4'b1111;
            step(1);
            owner = nxt;
        end
        chk("trace_after_rr", trace_signal, 32'h0005_0001);
        m_cyc_i_all = 4'b0000;
        push(1, 4'b0000, 4'b0000, 1'b0);
        step(2);

        // No preemption: master 2 holds while master 0 waits 50 cycles.
        m_cyc_i_all = 4'b0100;
        push(1, 4'b0100, 4'b0000, 1'b0);
        step(1);
        m_cyc_i_all = 4'b0101;
        step(50);
        chk("hold_no_preempt", 32'(grant_onehot), 32'h4);
        m_cyc_i_all = 4'b0001;
        push(1, 4'b0000, 4'b0000, 1'b0);
        push(2, 4'b0001, 4'b0000, 1'b0);
        step(2);
        m_cyc_i_all = 4'b0000;
        push(1, 4'b0000, 4'b0000, 1'b0);
        step(2);

        // Reset mid-grant: grant drops asynchronously, no error.
        m_cyc_i_all = 4'b0010;
        push(1, 4'b0010, 4'b0000, 1'b0);
        step(3);
        @(negedge clk);
        #2;
        push(1, 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        #1;
        chk("async_reset_grant", 32'(grant_onehot), 32'h0);
        chk("async_reset_err", 32'({m_err_o_all, trigger}), 32'h0);
        step(2);
        reset = 1'b1;
        push(1, 4'b0010, 4'b0000, 1'b0);
        step(1);
        chk("trace_after_reset", trace_signal, 32'h0001_0101);
        m_cyc_i_all = 4'b0000;
        push(1, 4'b0000, 4'b0000, 1'b0);
        step(2);

`ifdef WB_ARB_TIMEOUT_EN
        // Timeout on master 1: error 9 edges after the grant appears.
        m_cyc_i_all = 4'b0010;
        push(1, 4'b0010, 4'b0000, 1'b0);
        push(10, 4'b0000, 4'b0010, 1'b1);
        push(11, 4'b0000, 4'b0000, 1'b0);
        step(15);
        chk("masked_no_regrant", 32'(grant_onehot), 32'h0);
        chk("trace_timeout_cnt", 32'(trace_signal[31:24]), 32'h1);
        m_cyc_i_all = 4'b0000;
        step(1);
        // Mask cleared by cyc=0; ack in the cycle the counter reaches 8.
        m_cyc_i_all = 4'b0010;
        push(1, 4'b0010, 4'b0000, 1'b0);
        step(9);
        any_s_ack = 1'b1;
        step(1);
        any_s_ack = 1'b0;
        step(5);
        m_cyc_i_all = 4'b0000;
        push(1, 4'b0000, 4'b0000, 1'b0);
        step(2);
        // cyc drop coinciding with the timeout cycle: plain release.
        m_cyc_i_all = 4'b0100;
        push(1, 4'b0100, 4'b0000, 1'b0);
        step(9);
        m_cyc_i_all = 4'b0000;
        push(1, 4'b0000, 4'b0000, 1'b0);
        step(3);
        chk("trace_timeout_total", 32'(trace_signal[31:24]), 32'h1);
`else
        // Without the watchdog a long stall keeps the grant and never errors.
        m_cyc_i_all = 4'b0010;
        push(1, 4'b0010, 4'b0000, 1'b0);
        step(2000);
        chk("stall_grant_held", 32'(grant_onehot), 32'h2);
        chk("stall_trace_top", 32'(trace_signal[31:24]), 32'h0);
        m_cyc_i_all = 4'b0000;
        push(1, 4'b0000, 4'b0000, 1'b0);
        step(3);
`endif

        step(3);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
